// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU core: sequencer states, opcode groups and PC op codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_REGRD  = 3'd2,
        S_ALU    = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Opcode groups are identified by the upper four bits of the decoder's 5-bit aluop.
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1101;
    localparam logic [3:0] OP_BR  = 4'b1100;
    localparam logic [3:0] OP_CMP = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

endpackage

// File: rtl/ctrl_unit.sv
// Multi-cycle control sequencer: FETCH, DECODE, REGRD, ALU, MEM, WB, with HALT.
// Define CTRL_MEMTIMEOUT_EN to bound memory waits and add the absorbing FAULT state.
module ctrl_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [4:0] I_opcode,
    input  logic       I_regwe,
    input  logic       I_brtaken,
    input  logic       I_memack,
    output logic       O_en_dec,
    output logic       O_en_regrd,
    output logic       O_en_alu,
    output logic       O_en_regwr,
    output logic       O_memreq,
    output logic       O_memwe,
    output logic       O_memsel,
    output logic [1:0] O_pc_op,
    output logic [2:0] O_state,
    output logic       O_halted,
    output logic       O_fault
);

    state_t     state;
    state_t     state_next;
    logic       br_flag;
    logic       regwe_q;
    logic       store_q;
    logic [3:0] op_grp;

    assign op_grp = I_opcode[4:1];

    logic unused_opcode_lsb;
    assign unused_opcode_lsb = I_opcode[0];

`ifdef CTRL_MEMTIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout_hit;

    assign timeout_hit = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    // Any state change clears the counter, which covers entry into FETCH and MEM.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if ((state == S_FETCH || state == S_MEM) && !I_memack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    localparam int unsigned unused_mem_timeout = MEM_TIMEOUT;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (I_memack) state_next = S_DECODE;
`ifdef CTRL_MEMTIMEOUT_EN
                else if (timeout_hit) state_next = S_FAULT;
`endif
            end
            S_DECODE: state_next = S_REGRD;
            S_REGRD:  state_next = (op_grp == OP_HLT) ? S_HALT : S_ALU;
            S_ALU:    state_next = (op_grp == OP_LD || op_grp == OP_ST) ? S_MEM : S_WB;
            S_MEM: begin
                if (I_memack) state_next = S_WB;
`ifdef CTRL_MEMTIMEOUT_EN
                else if (timeout_hit) state_next = S_FAULT;
`endif
            end
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
`ifdef CTRL_MEMTIMEOUT_EN
            S_FAULT:  state_next = S_FAULT;
`endif
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Per-instruction attributes are captured in ALU so WB/MEM decode from registers only.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            br_flag <= 1'b0;
            regwe_q <= 1'b0;
            store_q <= 1'b0;
        end else if (state == S_ALU) begin
            br_flag <= (op_grp == OP_BR) && I_brtaken;
            regwe_q <= I_regwe;
            store_q <= (op_grp == OP_ST);
        end else if (state == S_WB) begin
            br_flag <= 1'b0;
        end
    end

    always_comb begin
        O_en_dec   = 1'b0;
        O_en_regrd = 1'b0;
        O_en_alu   = 1'b0;
        O_en_regwr = 1'b0;
        O_memreq   = 1'b0;
        O_memwe    = 1'b0;
        O_memsel   = 1'b0;
        O_pc_op    = PC_HOLD;
        O_halted   = 1'b0;
        O_fault    = 1'b0;
        case (state)
            S_FETCH:  O_memreq = 1'b1;
            S_DECODE: O_en_dec = 1'b1;
            S_REGRD:  O_en_regrd = 1'b1;
            S_ALU:    O_en_alu = 1'b1;
            S_MEM: begin
                O_memreq = 1'b1;
                O_memsel = 1'b1;
                O_memwe  = store_q;
            end
            S_WB: begin
                O_en_regwr = regwe_q;
                O_pc_op    = br_flag ? PC_LOAD : PC_INC;
            end
            S_HALT:   O_halted = 1'b1;
`ifdef CTRL_MEMTIMEOUT_EN
            S_FAULT:  O_fault = 1'b1;
`endif
            default: ;
        endcase
    end

    assign O_state = state;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed self-checking bench for ctrl_unit; FAULT behaviour checked only with CTRL_MEMTIMEOUT_EN.
module tb_ctrl_unit;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic       regwe;
    logic       brtaken;
    logic       ack;
    logic       en_dec, en_regrd, en_alu, en_regwr;
    logic       memreq, memwe, memsel;
    logic [1:0] pc_op;
    logic [2:0] state;
    logic       halted, fault;

    int total;
    int bad;

    ctrl_unit #(.MEM_TIMEOUT(4)) dut (
        .I_clk      (clk),
        .I_rst      (rst),
        .I_opcode   (opcode),
        .I_regwe    (regwe),
        .I_brtaken  (brtaken),
        .I_memack   (ack),
        .O_en_dec   (en_dec),
        .O_en_regrd (en_regrd),
        .O_en_alu   (en_alu),
        .O_en_regwr (en_regwr),
        .O_memreq   (memreq),
        .O_memwe    (memwe),
        .O_memsel   (memsel),
        .O_pc_op    (pc_op),
        .O_state    (state),
        .O_halted   (halted),
        .O_fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || memreq !== 1'b1 || memsel !== 1'b0 || memwe !== 1'b0) begin
            bad++;
            $display("FAIL reset_fetch: state=%0d memreq=%b memsel=%b memwe=%b, want 0 1 0 0",
                     state, memreq, memsel, memwe);
        end
        total++;
        if ({en_dec, en_regrd, en_alu, en_regwr} !== 4'b0000 || pc_op !== 2'b00 ||
            halted !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: en=%b pc_op=%b halted=%b fault=%b, want 0000 00 0 0",
                     {en_dec, en_regrd, en_alu, en_regwr}, pc_op, halted, fault);
        end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [2:0] exp_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
        int regwr_pulses = 0;
        opcode = 5'b00000;
        regwe  = 1'b1;
        ack    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            ack = 1'b0;
            if (en_regwr === 1'b1) regwr_pulses++;
            total++;
            if (state !== exp_seq[i]) begin
                bad++;
                $display("FAIL add_seq[%0d]: state=%0d want %0d", i, state, exp_seq[i]);
            end
            total++;
            if ($countones({en_dec, en_regrd, en_alu, en_regwr}) > 1) begin
                bad++;
                $display("FAIL add_onehot[%0d]: en=%b want at most one bit set", i,
                         {en_dec, en_regrd, en_alu, en_regwr});
            end
            if (i == 0) begin
                total++;
                if (en_dec !== 1'b1) begin
                    bad++;
                    $display("FAIL add_en_dec: got %b want 1", en_dec);
                end
            end
            if (i == 3) begin
                total++;
                if (pc_op !== 2'b01) begin
                    bad++;
                    $display("FAIL add_wb_pc_op: got %b want 01", pc_op);
                end
            end
        end
        total++;
        if (regwr_pulses != 1) begin
            bad++;
            $display("FAIL add_regwr_pulses: got %0d want 1", regwr_pulses);
        end
    endtask

    task automatic test_ld_st();
        logic [4:0] ops   [2] = '{5'b10000, 5'b11010};
        logic       wes   [2] = '{1'b1, 1'b0};
        logic       memws [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            regwe  = wes[k];
            ack    = 1'b1;
            tick();
            ack = 1'b0;
            tick();
            tick();
            tick();
            for (int c = 0; c < 3; c++) begin
                total++;
                if (state !== 3'd4 || memsel !== 1'b1 || memreq !== 1'b1 || memwe !== memws[k]) begin
                    bad++;
                    $display("FAIL ldst%0d_mem[%0d]: state=%0d sel=%b req=%b we=%b want 4 1 1 %b",
                             k, c, state, memsel, memreq, memwe, memws[k]);
                end
                if (c == 2) ack = 1'b1;
                tick();
                ack = 1'b0;
            end
            total++;
            if (state !== 3'd5 || en_regwr !== wes[k] || pc_op !== 2'b01) begin
                bad++;
                $display("FAIL ldst%0d_wb: state=%0d regwr=%b pc_op=%b want 5 %b 01",
                         k, state, en_regwr, pc_op, wes[k]);
            end
            tick();
        end
    endtask

    task automatic test_br();
        logic       taken [2] = '{1'b1, 1'b0};
        logic [1:0] exp_pc [2] = '{2'b10, 2'b01};
        for (int k = 0; k < 2; k++) begin
            opcode  = 5'b11000;
            regwe   = 1'b0;
            brtaken = taken[k];
            ack     = 1'b1;
            tick();
            ack = 1'b0;
            tick();
            tick();
            ack = 1'b1;
            total++;
            if (state !== 3'd3 || en_alu !== 1'b1) begin
                bad++;
                $display("FAIL br%0d_alu: state=%0d en_alu=%b want 3 1", k, state, en_alu);
            end
            tick();
            ack = 1'b0;
            brtaken = 1'b0;
            total++;
            if (state !== 3'd5 || pc_op !== exp_pc[k] || en_regwr !== 1'b0) begin
                bad++;
                $display("FAIL br%0d_wb: state=%0d pc_op=%b regwr=%b want 5 %b 0",
                         k, state, pc_op, en_regwr, exp_pc[k]);
            end
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL ack_in_decode: state=%0d want 2", state);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_abort();
        opcode = 5'b11010;
        regwe  = 1'b0;
        ack    = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (state !== 3'd4 || memwe !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre: state=%0d memwe=%b want 4 1", state, memwe);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || memwe !== 1'b0 || memsel !== 1'b0 || en_regwr !== 1'b0 || pc_op !== 2'b00) begin
            bad++;
            $display("FAIL abort_rst: state=%0d we=%b sel=%b regwr=%b pc_op=%b want 0 0 0 0 00",
                     state, memwe, memsel, en_regwr, pc_op);
        end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_halt();
        opcode = 5'b11110;
        regwe  = 1'b0;
        ack    = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 3'd6 || halted !== 1'b1 || memreq !== 1'b0) begin
            bad++;
            $display("FAIL halt_enter: state=%0d halted=%b memreq=%b want 6 1 0", state, halted, memreq);
        end
        for (int c = 0; c < 20; c++) begin
            ack = c[0];
            tick();
            total++;
            if (state !== 3'd6 || halted !== 1'b1) begin
                bad++;
                $display("FAIL halt_hold[%0d]: state=%0d halted=%b want 6 1", c, state, halted);
            end
        end
        ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || halted !== 1'b0 || memreq !== 1'b1) begin
            bad++;
            $display("FAIL halt_reset: state=%0d halted=%b memreq=%b want 0 0 1", state, halted, memreq);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_timeout();
        ack = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
`ifdef CTRL_MEMTIMEOUT_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (state !== 3'd0 || fault !== 1'b0) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: state=%0d fault=%b want 0 0", c, state, fault);
            end
        end
        tick();
        total++;
        if (state !== 3'd7 || fault !== 1'b1 || memreq !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fault: state=%0d fault=%b memreq=%b want 7 1 0", state, fault, memreq);
        end
        ack = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        ack = 1'b0;
        total++;
        if (state !== 3'd7 || fault !== 1'b1) begin
            bad++;
            $display("FAIL timeout_absorb: state=%0d fault=%b want 7 1", state, fault);
        end
`else
        for (int c = 0; c < 300; c++) tick();
        total++;
        if (state !== 3'd0 || memreq !== 1'b1 || fault !== 1'b0) begin
            bad++;
            $display("FAIL no_timeout: state=%0d memreq=%b fault=%b want 0 1 0", state, memreq, fault);
        end
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        opcode  = 5'b00000;
        regwe   = 1'b0;
        brtaken = 1'b0;
        ack     = 1'b0;
        test_reset();
        test_add();
        test_ld_st();
        test_br();
        test_abort();
        test_halt();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
